// File: rtl/instr_mem_reader_pkg.sv
// Constants and state type shared by the instruction-memory loader, reader and memory.
// Keeps word width, depth and address width consistent across the slice.
package instr_mem_reader_pkg;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PRESENT,
        DONE
    } rd_state_e;

    // A request longer than the memory reads each entry at most once.
    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
        return (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/instr_mem_reader_if.sv
// Command, memory read port and byte stream of the instruction-memory reader.
// master is the reader itself; slave is the memory/consumer/controller side.
interface instr_mem_reader_if;
    import instr_mem_reader_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_rdata;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, start_addr, len, abort, mem_rdata, out_ready,
        output mem_rd_en, mem_addr, out_data, out_valid, busy, done
    );

    modport slave (
        output start, start_addr, len, abort, mem_rdata, out_ready,
        input  mem_rd_en, mem_addr, out_data, out_valid, busy, done
    );

endinterface

// File: rtl/instr_mem_reader.sv
// Dumps a run of instruction-memory words onto a valid/ready byte stream.
// One word in flight at a time: issue read, capture data, present until accepted.
module instr_mem_reader
    import instr_mem_reader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    instr_mem_reader_if.master  bus
);

    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

    rd_state_e         state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   rem;
    logic              mem_rd_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W:0]   start_rem;

    assign start_rem = clamp_len(bus.len);

    // NOTE: every register here uses <= so all next-state terms see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            rem         <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (bus.abort && state != IDLE) begin
            // A word presented alongside abort is dropped, not accepted.
            state       <= IDLE;
            rem         <= '0;
            mem_rd_en_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        addr   <= bus.start_addr;
                        rem    <= start_rem;
                        busy_q <= 1'b1;
                        if (start_rem == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= bus.start_addr;
                        end
                    end
                end
                ISSUE: begin
                    mem_rd_en_q <= 1'b0;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    out_data_q  <= bus.mem_rdata;
                    out_valid_q <= 1'b1;
                    state       <= PRESENT;
                end
                PRESENT: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        rem         <= rem - REM_ONE;
                        if (rem == REM_ONE) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            addr        <= next_addr(addr);
                            mem_addr_q  <= next_addr(addr);
                            mem_rd_en_q <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
